// File: rtl/mc_alu.sv
// Handshaked multi-cycle ALU: single-cycle ops finish in one cycle, MUL (shift-add)
// and DIV (restoring) iterate for WIDTH cycles; results are held until consumed.
module mc_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [4:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               overflow,
  output logic               zero,
  output logic               busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = ~MIN_W;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_MUL  = 5'h02;
  localparam logic [4:0] OP_DIV  = 5'h03;
  localparam logic [4:0] OP_INC  = 5'h04;
  localparam logic [4:0] OP_DEC  = 5'h05;
  localparam logic [4:0] OP_NEG  = 5'h06;
  localparam logic [4:0] OP_ABS  = 5'h07;
  localparam logic [4:0] OP_AND  = 5'h08;
  localparam logic [4:0] OP_OR   = 5'h09;
  localparam logic [4:0] OP_XOR  = 5'h0A;
  localparam logic [4:0] OP_NOT  = 5'h0B;
  localparam logic [4:0] OP_NAND = 5'h0C;
  localparam logic [4:0] OP_NOR  = 5'h0D;
  localparam logic [4:0] OP_XNOR = 5'h0E;
  localparam logic [4:0] OP_ANDN = 5'h0F;
  localparam logic [4:0] OP_SHL  = 5'h10;
  localparam logic [4:0] OP_SHR  = 5'h11;
  localparam logic [4:0] OP_SAR  = 5'h12;
  localparam logic [4:0] OP_ROL  = 5'h13;
  localparam logic [4:0] OP_ROR  = 5'h14;
  localparam logic [4:0] OP_RCL  = 5'h15;
  localparam logic [4:0] OP_RCR  = 5'h16;
  localparam logic [4:0] OP_SWAP = 5'h17;
  localparam logic [4:0] OP_EQ   = 5'h18;
  localparam logic [4:0] OP_NE   = 5'h19;
  localparam logic [4:0] OP_GT   = 5'h1A;
  localparam logic [4:0] OP_LT   = 5'h1B;
  localparam logic [4:0] OP_SET  = 5'h1C;
  localparam logic [4:0] OP_CLR  = 5'h1D;
  localparam logic [4:0] OP_TGL  = 5'h1E;
  localparam logic [4:0] OP_PAR  = 5'h1F;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   accHi_q, accHi_d;
  logic [WIDTH-1:0]   accLo_q, accLo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               valid_q, valid_d;
  logic               readyInt;

  logic [WIDTH-1:0]        aluLo;
  logic                    aluCarry, aluOvf;
  logic [WIDTH:0]          sumW, shlW, shrW;
  logic signed [WIDTH:0]   sarW;
  logic [WIDTH-1:0]        bitMask, negA;
  logic [SHW-1:0]          amt;

  // Single-cycle datapath; the carry-style flags come from an extra MSB/LSB on the shifters.
  always_comb begin
    amt      = B[SHW-1:0];
    aluLo    = '0;
    aluCarry = 1'b0;
    aluOvf   = 1'b0;
    sumW     = '0;
    negA     = ~A + ONE_W;
    bitMask  = ONE_W << amt;
    shlW     = {1'b0, A} << amt;
    shrW     = {A, 1'b0} >> amt;
    sarW     = $signed({A, 1'b0}) >>> amt;
    case (opcode)
      OP_ADD: begin
        sumW     = {1'b0, A} + {1'b0, B};
        aluLo    = sumW[WIDTH-1:0];
        aluCarry = sumW[WIDTH];
        aluOvf   = (A[WIDTH-1] == B[WIDTH-1]) && (sumW[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sumW     = {1'b0, A} - {1'b0, B};
        aluLo    = sumW[WIDTH-1:0];
        aluCarry = sumW[WIDTH];
        aluOvf   = (A[WIDTH-1] != B[WIDTH-1]) && (sumW[WIDTH-1] != A[WIDTH-1]);
      end
      OP_INC: begin
        sumW     = {1'b0, A} + {1'b0, ONE_W};
        aluLo    = sumW[WIDTH-1:0];
        aluCarry = sumW[WIDTH];
        aluOvf   = (A == MAX_POS);
      end
      OP_DEC: begin
        sumW     = {1'b0, A} - {1'b0, ONE_W};
        aluLo    = sumW[WIDTH-1:0];
        aluCarry = sumW[WIDTH];
        aluOvf   = (A == MIN_W);
      end
      OP_NEG:  aluLo = negA;
      OP_ABS: begin
        aluLo  = A[WIDTH-1] ? negA : A;
        aluOvf = (A == MIN_W);
      end
      OP_AND:  aluLo = A & B;
      OP_OR:   aluLo = A | B;
      OP_XOR:  aluLo = A ^ B;
      OP_NOT:  aluLo = ~A;
      OP_NAND: aluLo = ~(A & B);
      OP_NOR:  aluLo = ~(A | B);
      OP_XNOR: aluLo = ~(A ^ B);
      OP_ANDN: aluLo = A & ~B;
      OP_SHL: begin
        aluLo    = shlW[WIDTH-1:0];
        aluCarry = shlW[WIDTH];
      end
      OP_SHR: begin
        aluLo    = shrW[WIDTH:1];
        aluCarry = shrW[0];
      end
      OP_SAR: begin
        aluLo    = sarW[WIDTH:1];
        aluCarry = sarW[0];
      end
      OP_ROL:  aluLo = (A << amt) | (A >> (WIDTH - int'(amt)));
      OP_ROR:  aluLo = (A >> amt) | (A << (WIDTH - int'(amt)));
      OP_RCL: begin
        aluLo    = {A[WIDTH-2:0], carry_q};
        aluCarry = A[WIDTH-1];
      end
      OP_RCR: begin
        aluLo    = {carry_q, A[WIDTH-1:1]};
        aluCarry = A[0];
      end
      OP_SWAP: aluLo = {A[WIDTH/2-1:0], A[WIDTH-1:WIDTH/2]};
      OP_EQ:   aluLo[0] = (A == B);
      OP_NE:   aluLo[0] = (A != B);
      OP_GT:   aluLo[0] = (A > B);
      OP_LT:   aluLo[0] = (A < B);
      OP_SET:  aluLo = A | bitMask;
      OP_CLR:  aluLo = A & ~bitMask;
      OP_TGL:  aluLo = A ^ bitMask;
      OP_PAR:  aluLo[0] = ^A;
      default: aluLo = '0;
    endcase
  end

  logic [WIDTH:0]   mulSum, divShift;
  logic [WIDTH-1:0] mulHi, mulLo, divRem, divQuo, divDiff;
  logic             divGe;

  // One iteration step of each sequential unit; accLo holds the multiplier or the dividend/quotient.
  always_comb begin
    mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : '0);
    mulHi    = mulSum[WIDTH:1];
    mulLo    = {mulSum[0], accLo_q[WIDTH-1:1]};
    divShift = {accHi_q, accLo_q[WIDTH-1]};
    divDiff  = divShift[WIDTH-1:0] - opnd_q;
    divGe    = (divShift >= {1'b0, opnd_q});
    divRem   = divGe ? divDiff : divShift[WIDTH-1:0];
    divQuo   = {accLo_q[WIDTH-2:0], divGe};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      accHi_q  <= '0;
      accLo_q  <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      accHi_q  <= accHi_d;
      accLo_q  <= accLo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accHi_d  = accHi_q;
    accLo_d  = accLo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    valid_d  = valid_q && !out_ready;
    readyInt = reset && (state_q == IDLE) && (!valid_q || out_ready);
    case (state_q)
      IDLE: begin
        if (in_valid && readyInt) begin
          if (opcode == OP_MUL) begin
            state_d = MUL;
            cnt_d   = CW'(WIDTH);
            accHi_d = '0;
            accLo_d = B;
            opnd_d  = A;
          end else if (opcode == OP_DIV) begin
            state_d = DIV;
            cnt_d   = CW'(WIDTH);
            accHi_d = '0;
            accLo_d = A;
            opnd_d  = B;
          end else begin
            result_d = {{WIDTH{1'b0}}, aluLo};
            carry_d  = aluCarry;
            ovf_d    = aluOvf;
            zero_d   = (aluLo == '0);
            valid_d  = 1'b1;
          end
        end
      end
      MUL: begin
        accHi_d = mulHi;
        accLo_d = mulLo;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = IDLE;
          result_d = {mulHi, mulLo};
          carry_d  = 1'b0;
          ovf_d    = (mulHi != '0);
          zero_d   = ({mulHi, mulLo} == '0);
          valid_d  = 1'b1;
        end
      end
      DIV: begin
        accHi_d = divRem;
        accLo_d = divQuo;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = IDLE;
          result_d = {divRem, divQuo};
          carry_d  = 1'b0;
          ovf_d    = (opnd_q == '0);
          zero_d   = ({divRem, divQuo} == '0);
          valid_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = readyInt;
  assign out_valid = valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mc_alu.sv
// Bench for mc_alu at WIDTH=8: directed handshake/back-pressure/reset steps, then
// random operations checked against an integer reference model.
module tb_mc_alu;
  localparam int W = 8;
  localparam int M = 1 << W;
  localparam int H = M / 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic [4:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [2*W-1:0] result;
  logic         carry, overflow, zero, busy;

  int tests = 0;
  int failed = 0;
  int modelCarry = 0;

  always #5 clk = ~clk;

  mc_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour computed on plain integers.
  function automatic void refModel(input int op, input int a, input int b, input int cin,
                                   output int res, output int c, output int o);
    int sa, sb, s, t;
    sa = (a >= H) ? a - M : a;
    sb = (b >= H) ? b - M : b;
    s  = b % W;
    res = 0; c = 0; o = 0;
    case (op)
      0: begin t = a + b; res = t % M; c = int'(t >= M); o = int'((sa + sb > H - 1) || (sa + sb < -H)); end
      1: begin res = (a - b + M) % M; c = int'(a < b); o = int'((sa - sb > H - 1) || (sa - sb < -H)); end
      2: begin res = a * b; o = int'(a * b >= M); end
      3: begin
        if (b == 0) begin res = a * M + (M - 1); o = 1; end
        else res = (a % b) * M + a / b;
      end
      4: begin t = a + 1; res = t % M; c = int'(t >= M); o = int'(sa + 1 > H - 1); end
      5: begin res = (a - 1 + M) % M; c = int'(a == 0); o = int'(sa - 1 < -H); end
      6: res = (M - a) % M;
      7: begin res = (sa < 0) ? (-sa) % M : a; o = int'(a == H); end
      8: res = a & b;
      9: res = a | b;
      10: res = a ^ b;
      11: res = (~a) & (M - 1);
      12: res = (~(a & b)) & (M - 1);
      13: res = (~(a | b)) & (M - 1);
      14: res = (~(a ^ b)) & (M - 1);
      15: res = a & ~b & (M - 1);
      16: begin res = (a << s) % M; c = (s == 0) ? 0 : (a >> (W - s)) & 1; end
      17: begin res = a >> s; c = (s == 0) ? 0 : (a >> (s - 1)) & 1; end
      18: begin res = (sa >>> s) & (M - 1); c = (s == 0) ? 0 : (sa >>> (s - 1)) & 1; end
      19: res = ((a << s) | (a >> (W - s))) % M;
      20: res = ((a >> s) | (a << (W - s))) % M;
      21: begin res = ((a << 1) | cin) % M; c = a / H; end
      22: begin res = (a >> 1) | (cin * H); c = a % 2; end
      23: res = (a % (1 << (W / 2))) * (1 << (W / 2)) + a / (1 << (W / 2));
      24: res = int'(a == b);
      25: res = int'(a != b);
      26: res = int'(a > b);
      27: res = int'(a < b);
      28: res = a | (1 << s);
      29: res = a & ~(1 << s) & (M - 1);
      30: res = a ^ (1 << s);
      default: res = $countones(a) % 2;
    endcase
  endfunction

  // Offers an operation and returns one time unit after the edge that accepts it.
  task automatic applyStimulus(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int waited = 0;
    opcode = op; A = a; B = b; in_valid = 1'b1;
    #1;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("acceptWait", 64'(waited < 50), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); opcode = 5'($urandom);
  endtask

  task automatic runOp(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int expRes, expC, expO, busyCnt;
    refModel(int'(op), int'(a), int'(b), modelCarry, expRes, expC, expO);
    applyStimulus(op, a, b);
    if (op == 5'h02 || op == 5'h03) begin
      busyCnt = 0;
      for (int i = 0; i < 40 && out_valid !== 1'b1; i++) begin
        if (busy === 1'b1 && in_ready === 1'b0) busyCnt++;
        @(posedge clk); #1;
        if (i < 40 - 1) A = W'($urandom);
      end
      checkOutput($sformatf("busyCycles op%0h", op), 64'(busyCnt), 64'(W));
    end
    checkOutput($sformatf("outValid op%0h", op), {63'd0, out_valid}, 64'd1);
    checkOutput($sformatf("result op%0h a=%0h b=%0h", op, a, b), {48'd0, result}, 64'(expRes));
    checkOutput($sformatf("carry op%0h a=%0h b=%0h", op, a, b), {63'd0, carry}, 64'(expC));
    checkOutput($sformatf("overflow op%0h a=%0h b=%0h", op, a, b), {63'd0, overflow}, 64'(expO));
    checkOutput($sformatf("zero op%0h a=%0h b=%0h", op, a, b), {63'd0, zero}, 64'(expRes == 0));
    modelCarry = expC;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sawValid;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; opcode = '0;
    #2;
    checkOutput("rstInReady", {63'd0, in_ready}, 64'd0);
    checkOutput("rstBusy", {63'd0, busy}, 64'd0);
    checkOutput("rstOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("rstResult", {48'd0, result}, 64'd0);
    checkOutput("rstFlags", {61'd0, carry, overflow, zero}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("readyAfterReset", {63'd0, in_ready}, 64'd1);

    runOp(5'h00, 8'h55, 8'h93);
    checkOutput("planAdd", {48'd0, result}, 64'h00E8);
    runOp(5'h00, 8'hFF, 8'h01);
    checkOutput("planAddWrap", {46'd0, carry, zero, result}, {46'd0, 1'b1, 1'b1, 16'h0000});

    runOp(5'h02, 8'h55, 8'h93);
    checkOutput("planMul", {47'd0, overflow, result}, {47'd0, 1'b1, 16'h30CF});
    @(posedge clk); #1;
    checkOutput("mulValidOneCycle", {63'd0, out_valid}, 64'd0);

    runOp(5'h03, 8'h55, 8'h13);
    checkOutput("planDiv", {47'd0, overflow, result}, {47'd0, 1'b0, 16'h0904});
    runOp(5'h03, 8'h55, 8'h00);
    checkOutput("planDivZero", {47'd0, overflow, result}, {47'd0, 1'b1, 16'h55FF});
    @(posedge clk); #1;

    out_ready = 1'b0;
    applyStimulus(5'h08, 8'h55, 8'h93);
    checkOutput("bpAndResult", {48'd0, result}, 64'h0011);
    opcode = 5'h09; A = 8'h55; B = 8'h93; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bpInReady", {63'd0, in_ready}, 64'd0);
      checkOutput("bpHeld", {47'd0, out_valid, result}, {47'd0, 1'b1, 16'h0011});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bpOrNoBubble", {47'd0, out_valid, result}, {47'd0, 1'b1, 16'h00D7});
    modelCarry = 0;

    runOp(5'h10, 8'h55, 8'h02);
    checkOutput("planShl", {47'd0, carry, result}, {47'd0, 1'b1, 16'h0054});
    runOp(5'h15, 8'h55, 8'h00);
    checkOutput("planRcl", {47'd0, carry, result}, {47'd0, 1'b0, 16'h00AB});
    runOp(5'h12, 8'h80, 8'h03);
    checkOutput("planSar", {48'd0, result}, 64'h00F0);

    applyStimulus(5'h03, 8'h55, 8'h13);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checkOutput("abortOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("abortResult", {48'd0, result}, 64'd0);
    checkOutput("abortBusy", {63'd0, busy}, 64'd0);
    checkOutput("abortInReady", {63'd0, in_ready}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    modelCarry = 0;
    @(posedge clk); #1;
    checkOutput("releaseReady", {62'd0, in_ready, busy}, {62'd0, 1'b1, 1'b0});
    sawValid = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) sawValid++;
      @(posedge clk); #1;
    end
    checkOutput("noStaleResult", 64'(sawValid), 64'd0);

    runOp(5'h00, 8'h7F, 8'h01);
    runOp(5'h01, 8'h80, 8'h01);
    runOp(5'h04, 8'h7F, 8'h00);
    runOp(5'h05, 8'h00, 8'h00);
    runOp(5'h07, 8'h80, 8'h00);
    runOp(5'h10, 8'hA5, 8'h00);
    runOp(5'h11, 8'hA5, 8'h08);
    runOp(5'h02, 8'hFF, 8'hFF);
    runOp(5'h02, 8'h00, 8'h37);
    runOp(5'h03, 8'hFF, 8'h01);
    runOp(5'h03, 8'h05, 8'hFF);

    for (int op = 0; op < 32; op++)
      runOp(5'(op), W'($urandom), W'($urandom));
    for (int n = 0; n < 150; n++)
      runOp(5'($urandom_range(0, 31)), W'($urandom), W'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
